// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the MEM pipeline stage (master) and the
// data memory controller (slave).
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. The request fields (req_we, req_size, req_sext, req_addr,
// req_wdata) must be stable whenever req_valid is high. rsp_valid, rsp_rdata
// and rsp_err stay stable until the edge where rsp_ready is high. Neither
// side may make valid depend on ready.
//
// state_dbg exposes the controller FSM state for observation only.
interface data_memory_ctrl_if #(
   parameter int ADDR_W = 11
) ();
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_sext;
   logic [ADDR_W-1:0] req_addr;
   logic [63:0]       req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [63:0]       rsp_rdata;
   logic              rsp_err;
   logic [1:0]        state_dbg;

   modport master (
      output req_valid, req_we, req_size, req_sext, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, state_dbg
   );

   modport slave (
      input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, state_dbg
   );
endinterface

// File: rtl/data_memory_ctrl.sv
// LEGv8 data memory controller: byte/half/word/dword loads and stores on a
// DEPTH x 64-bit little-endian array, with optional sign extension, a fixed
// programmable read latency (READ_LAT, 1..4) and error flagging for
// misaligned or out-of-range addresses.
//
// Optional feature macro: DMEM_WATCH_EN
//   defined   -> adds parameter WATCH_IDX and output watch_data, a registered
//                mirror of mem[WATCH_IDX] (reset value 0).
//   undefined -> no watch port, parameter or register.
module data_memory_ctrl #(
   parameter int DEPTH    = 256,
   parameter int ADDR_W   = 11,
   parameter int READ_LAT = 1
`ifdef DMEM_WATCH_EN
   ,
   parameter int WATCH_IDX = 6
`endif
) (
   input logic              clk,
   input logic              rst_n,
   data_memory_ctrl_if.slave bus
`ifdef DMEM_WATCH_EN
   ,
   output logic [63:0]      watch_data
`endif
);

   localparam int DW_W = ADDR_W - 3;
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [DW_W:0] DEPTH_LIM = (DW_W + 1)'(DEPTH);
   localparam logic [2:0] LAST_CNT = 3'(READ_LAT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [63:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;

   // Backing array; deliberately not reset so a reset never loses stored data.
   logic [63:0] mem [DEPTH];

   logic [DW_W-1:0]  dw_idx;
   logic [2:0]       byte_off;
   logic [5:0]       bit_off;
   logic [IDX_W-1:0] mem_idx;
   logic             misaligned;
   logic             out_of_range;
   logic             acc_err;
   logic             accept;
   logic             do_write;
   logic [7:0]       size_mask;
   logic [7:0]       wr_be;
   logic [63:0]      wr_data;
   logic [63:0]      rd_shift;
   logic [63:0]      load_val;

   // Address decode, alignment/range checks and lane steering for both directions
   always_comb begin
      dw_idx       = bus.req_addr[ADDR_W-1:3];
      byte_off     = bus.req_addr[2:0];
      bit_off      = {byte_off, 3'b000};
      mem_idx      = dw_idx[IDX_W-1:0];
      out_of_range = ({1'b0, dw_idx} >= DEPTH_LIM);
      misaligned   = 1'b0;
      size_mask    = 8'h01;
      case (bus.req_size)
         2'd0: begin misaligned = 1'b0;          size_mask = 8'h01; end
         2'd1: begin misaligned = byte_off[0];   size_mask = 8'h03; end
         2'd2: begin misaligned = |byte_off[1:0]; size_mask = 8'h0F; end
         default: begin misaligned = |byte_off;  size_mask = 8'hFF; end
      endcase
      acc_err  = misaligned | out_of_range;
      // Reset holds off acceptance so nothing is written while rst_n is low.
      accept   = bus.req_valid & (state_q == ST_IDLE) & rst_n;
      do_write = accept & bus.req_we & ~acc_err;
      wr_be    = size_mask << byte_off;
      wr_data  = bus.req_wdata << bit_off;
      rd_shift = mem[mem_idx] >> bit_off;
      load_val = rd_shift;
      case (bus.req_size)
         2'd0: load_val = {{56{bus.req_sext & rd_shift[7]}},  rd_shift[7:0]};
         2'd1: load_val = {{48{bus.req_sext & rd_shift[15]}}, rd_shift[15:0]};
         2'd2: load_val = {{32{bus.req_sext & rd_shift[31]}}, rd_shift[31:0]};
         default: load_val = rd_shift;
      endcase
   end

   // Byte-enabled array write committed at the accept edge
   always_ff @(posedge clk) begin
      if (do_write) begin
         for (int b = 0; b < 8; b++) begin
            if (wr_be[b]) mem[mem_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
         end
      end
   end

   // FSM next state and response capture; load data is sampled at accept time
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               rsp_err_d   = acc_err;
               rsp_rdata_d = (acc_err | bus.req_we) ? 64'd0 : load_val;
               if (READ_LAT == 1) begin
                  state_d = ST_RESP;
                  cnt_d   = 3'd0;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = 3'd1;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == LAST_CNT) begin
               state_d = ST_RESP;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state, latency counter and response registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 3'd0;
         rsp_rdata_q <= 64'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign bus.req_ready = (state_q == ST_IDLE);
   assign bus.rsp_valid = (state_q == ST_RESP);
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.state_dbg = state_q;

`ifdef DMEM_WATCH_EN
   logic [63:0] watch_data_q, watch_data_d;

   // Watched doubleword as currently stored
   always_comb begin
      watch_data_d = mem[IDX_W'(WATCH_IDX)];
   end

   // Registered mirror, so it lags array writes by one edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) watch_data_q <= 64'd0;
      else        watch_data_q <= watch_data_d;
   end

   assign watch_data = watch_data_q;
`endif

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: two instances (READ_LAT=1/DEPTH=256 and
// READ_LAT=3/DEPTH=200) sharing one request driver, checked against a
// byte-level reference model of each array.
`timescale 1ns/1ps
module tb_data_memory_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          t_sel = 0;
   logic        t_valid = 1'b0;
   logic        t_we = 1'b0;
   logic [1:0]  t_size = 2'd0;
   logic        t_sext = 1'b0;
   logic [10:0] t_addr = '0;
   logic [63:0] t_wdata = '0;
   logic        t_rsp_ready = 1'b0;

   int n_tests = 0;
   int n_fail = 0;

   logic [63:0] mdl [2][256];

   data_memory_ctrl_if #(.ADDR_W(11)) bus1 ();
   data_memory_ctrl_if #(.ADDR_W(11)) bus3 ();

`ifdef DMEM_WATCH_EN
   logic [63:0] watch1, watch3;
`endif

   data_memory_ctrl #(.DEPTH(256), .ADDR_W(11), .READ_LAT(1)) dut1 (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus1.slave)
`ifdef DMEM_WATCH_EN
      ,
      .watch_data(watch1)
`endif
   );

   data_memory_ctrl #(.DEPTH(200), .ADDR_W(11), .READ_LAT(3)) dut3 (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus3.slave)
`ifdef DMEM_WATCH_EN
      ,
      .watch_data(watch3)
`endif
   );

   assign bus1.req_valid = t_valid && (t_sel == 0);
   assign bus3.req_valid = t_valid && (t_sel == 1);
   assign bus1.rsp_ready = t_rsp_ready && (t_sel == 0);
   assign bus3.rsp_ready = t_rsp_ready && (t_sel == 1);
   assign bus1.req_we = t_we;
   assign bus3.req_we = t_we;
   assign bus1.req_size = t_size;
   assign bus3.req_size = t_size;
   assign bus1.req_sext = t_sext;
   assign bus3.req_sext = t_sext;
   assign bus1.req_addr = t_addr;
   assign bus3.req_addr = t_addr;
   assign bus1.req_wdata = t_wdata;
   assign bus3.req_wdata = t_wdata;

   logic        o_req_ready, o_rsp_valid, o_rsp_err;
   logic [63:0] o_rsp_rdata;
   assign o_req_ready = (t_sel == 1) ? bus3.req_ready : bus1.req_ready;
   assign o_rsp_valid = (t_sel == 1) ? bus3.rsp_valid : bus1.rsp_valid;
   assign o_rsp_err   = (t_sel == 1) ? bus3.rsp_err   : bus1.rsp_err;
   assign o_rsp_rdata = (t_sel == 1) ? bus3.rsp_rdata : bus1.rsp_rdata;

   // Clock
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   function automatic int depth_of(input int sel);
      return (sel == 1) ? 200 : 256;
   endfunction

   function automatic int lat_of(input int sel);
      return (sel == 1) ? 3 : 1;
   endfunction

   // Reference model: a store updates the addressed bytes, a load gathers them
   // and extends the top bit; errors touch nothing and return zero.
   function automatic void ref_access(input int sel, input bit we, input logic [1:0] size,
                                      input bit sext, input logic [10:0] addr, input logic [63:0] wdata,
                                      output logic [63:0] exp_rd, output bit exp_err);
      int nb;
      int off;
      int idx;
      logic [63:0] v;
      nb = 1 << size;
      off = int'(addr) % 8;
      idx = int'(addr) / 8;
      exp_rd = 64'd0;
      v = 64'd0;
      exp_err = ((off % nb) != 0) || (idx >= depth_of(sel));
      if (exp_err) return;
      if (we) begin
         for (int b = 0; b < nb; b++) mdl[sel][idx][(off+b)*8 +: 8] = wdata[b*8 +: 8];
      end else begin
         for (int b = 0; b < nb; b++) v[b*8 +: 8] = mdl[sel][idx][(off+b)*8 +: 8];
         if (sext && size != 2'd3 && v[nb*8-1]) begin
            for (int bb = nb * 8; bb < 64; bb++) v[bb] = 1'b1;
         end
         exp_rd = v;
      end
   endfunction

   // Driver: one full request/response transaction; starts and ends at a negedge.
   task automatic xact(input int sel, input bit we, input logic [1:0] size, input bit sext,
                       input logic [10:0] addr, input logic [63:0] wdata, input int hold,
                       output logic [63:0] got_rd, output logic got_err, output int got_lat,
                       output bit got_stable, output bit got_idle, output int acc_cyc);
      int waited;
      got_rd = '0; got_err = 1'b0; got_lat = -1; got_stable = 1'b1; got_idle = 1'b0; acc_cyc = -1;
      t_sel = sel; t_we = we; t_size = size; t_sext = sext; t_addr = addr; t_wdata = wdata;
      t_valid = 1'b1;
      waited = 0;
      while (!o_req_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!o_req_ready) begin
         t_valid = 1'b0;
         return;
      end
      @(posedge clk);
      acc_cyc = int'($time / 10);
      #1 t_valid = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (o_rsp_valid) begin
            got_lat = k;
            break;
         end
         if (o_req_ready) got_stable = 1'b0;
      end
      if (got_lat < 0) return;
      got_rd = o_rsp_rdata;
      got_err = o_rsp_err;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         if (!o_rsp_valid || o_rsp_rdata !== got_rd || o_rsp_err !== got_err || o_req_ready !== 1'b0)
            got_stable = 1'b0;
      end
      t_rsp_ready = 1'b1;
      @(posedge clk);
      #1 t_rsp_ready = 1'b0;
      @(negedge clk);
      got_idle = o_req_ready && !o_rsp_valid;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      n_tests++; if (bus1.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready1 got=%b exp=1", bus1.req_ready); end
      n_tests++; if (bus1.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid1 got=%b exp=0", bus1.rsp_valid); end
      n_tests++; if (bus1.rsp_rdata !== 64'd0) begin n_fail++; $display("FAIL reset_rdata1 got=%h exp=0", bus1.rsp_rdata); end
      n_tests++; if (bus1.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err1 got=%b exp=0", bus1.rsp_err); end
      n_tests++; if (bus3.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready3 got=%b exp=1", bus3.req_ready); end
      n_tests++; if (bus3.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid3 got=%b exp=0", bus3.rsp_valid); end
`ifdef DMEM_WATCH_EN
      n_tests++; if (watch1 !== 64'd0) begin n_fail++; $display("FAIL reset_watch got=%h exp=0", watch1); end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Zero both arrays so every later load has a known model value.
   task automatic prefill();
      logic [63:0] rd; logic er; int lat, ac; bit st, idl;
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < depth_of(s); i++) begin
            xact(s, 1'b1, 2'd3, 1'b0, 11'(i * 8), 64'd0, 0, rd, er, lat, st, idl, ac);
            mdl[s][i] = 64'd0;
         end
      end
   endtask

   task automatic test_dword_store_load();
      logic [63:0] rd, erd; logic er; bit eer; int lat, ac; bit st, idl;
      ref_access(0, 1'b1, 2'd3, 1'b0, 11'h030, 64'h1122334455667788, erd, eer);
      xact(0, 1'b1, 2'd3, 1'b0, 11'h030, 64'h1122334455667788, 0, rd, er, lat, st, idl, ac);
      n_tests++; if (rd !== 64'd0 || er !== 1'b0) begin n_fail++; $display("FAIL dword_store_rsp got=%h/%b exp=0/0", rd, er); end
      n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL dword_store_lat got=%0d exp=1", lat); end
      ref_access(0, 1'b0, 2'd3, 1'b0, 11'h030, 64'd0, erd, eer);
      xact(0, 1'b0, 2'd3, 1'b0, 11'h030, 64'd0, 0, rd, er, lat, st, idl, ac);
      n_tests++; if (rd !== 64'h1122334455667788) begin n_fail++; $display("FAIL dword_load got=%h exp=1122334455667788", rd); end
      n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL dword_load_err got=%b exp=0", er); end
      n_tests++; if (idl !== 1'b1) begin n_fail++; $display("FAIL dword_load_idle got=%b exp=1", idl); end
   endtask

   task automatic test_byte_sext();
      logic [63:0] rd, erd; logic er; bit eer; int lat, ac; bit st, idl;
      ref_access(0, 1'b1, 2'd0, 1'b0, 11'h031, 64'h00000000000000F0, erd, eer);
      xact(0, 1'b1, 2'd0, 1'b0, 11'h031, 64'h00000000000000F0, 0, rd, er, lat, st, idl, ac);
      ref_access(0, 1'b0, 2'd0, 1'b1, 11'h031, 64'd0, erd, eer);
      xact(0, 1'b0, 2'd0, 1'b1, 11'h031, 64'd0, 0, rd, er, lat, st, idl, ac);
      n_tests++; if (rd !== 64'hFFFFFFFFFFFFFFF0) begin n_fail++; $display("FAIL byte_sext got=%h exp=fffffffffffffff0", rd); end
      xact(0, 1'b0, 2'd0, 1'b0, 11'h031, 64'd0, 0, rd, er, lat, st, idl, ac);
      n_tests++; if (rd !== 64'h00000000000000F0) begin n_fail++; $display("FAIL byte_zext got=%h exp=f0", rd); end
      xact(0, 1'b0, 2'd3, 1'b0, 11'h030, 64'd0, 0, rd, er, lat, st, idl, ac);
      n_tests++; if (rd !== 64'h112233445566F088) begin n_fail++; $display("FAIL byte_merge got=%h exp=112233445566f088", rd); end
      xact(0, 1'b0, 2'd1, 1'b1, 11'h032, 64'd0, 0, rd, er, lat, st, idl, ac);
      n_tests++; if (rd !== 64'h0000000000005566) begin n_fail++; $display("FAIL half_sext_pos got=%h exp=5566", rd); end
   endtask

   task automatic test_errors();
      logic [63:0] rd, erd; logic er; bit eer; int lat, ac; bit st, idl;
      xact(0, 1'b0, 2'd2, 1'b0, 11'h002, 64'd0, 0, rd, er, lat, st, idl, ac);
      n_tests++; if (er !== 1'b1 || rd !== 64'd0) begin n_fail++; $display("FAIL word_misaligned got=%h/%b exp=0/1", rd, er); end
      xact(0, 1'b1, 2'd1, 1'b0, 11'h7FF, 64'hFFFFFFFFFFFFFFFF, 0, rd, er, lat, st, idl, ac);
      n_tests++; if (er !== 1'b1 || rd !== 64'd0) begin n_fail++; $display("FAIL half_store_misaligned got=%h/%b exp=0/1", rd, er); end
      ref_access(0, 1'b0, 2'd3, 1'b0, 11'h7F8, 64'd0, erd, eer);
      xact(0, 1'b0, 2'd3, 1'b0, 11'h7F8, 64'd0, 0, rd, er, lat, st, idl, ac);
      n_tests++; if (rd !== erd || er !== 1'b0) begin n_fail++; $display("FAIL erroring_store_wrote got=%h/%b exp=%h/0", rd, er, erd); end
      xact(1, 1'b1, 2'd3, 1'b0, 11'h640, 64'h0123456789ABCDEF, 0, rd, er, lat, st, idl, ac);
      n_tests++; if (er !== 1'b1 || rd !== 64'd0) begin n_fail++; $display("FAIL out_of_range_store got=%h/%b exp=0/1", rd, er); end
      ref_access(1, 1'b1, 2'd3, 1'b0, 11'h638, 64'h8877665544332211, erd, eer);
      xact(1, 1'b1, 2'd3, 1'b0, 11'h638, 64'h8877665544332211, 0, rd, er, lat, st, idl, ac);
      n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL last_index_store_err got=%b exp=0", er); end
      ref_access(1, 1'b0, 2'd2, 1'b1, 11'h63C, 64'd0, erd, eer);
      xact(1, 1'b0, 2'd2, 1'b1, 11'h63C, 64'd0, 0, rd, er, lat, st, idl, ac);
      n_tests++; if (rd !== erd || rd !== 64'hFFFFFFFF88776655) begin n_fail++; $display("FAIL last_index_word_sext got=%h exp=ffffffff88776655", rd); end
   endtask

   task automatic test_latency_hold();
      logic [63:0] rd, erd; logic er; bit eer; int lat, ac; bit st, idl;
      ref_access(1, 1'b0, 2'd3, 1'b0, 11'h638, 64'd0, erd, eer);
      xact(1, 1'b0, 2'd3, 1'b0, 11'h638, 64'd0, 5, rd, er, lat, st, idl, ac);
      n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL lat3_first_valid got=%0d exp=3", lat); end
      n_tests++; if (st !== 1'b1) begin n_fail++; $display("FAIL lat3_hold_stable got=%b exp=1", st); end
      n_tests++; if (rd !== erd) begin n_fail++; $display("FAIL lat3_rdata got=%h exp=%h", rd, erd); end
      n_tests++; if (idl !== 1'b1) begin n_fail++; $display("FAIL lat3_return_idle got=%b exp=1", idl); end
   endtask

   task automatic test_reset_mid();
      logic [63:0] rd, erd; logic er; bit eer; int lat, ac; bit st, idl;
      bit dropped_ok;
      int waited;
      ref_access(1, 1'b1, 2'd3, 1'b0, 11'h008, 64'h00000000000000AA, erd, eer);
      t_sel = 1; t_we = 1'b1; t_size = 2'd3; t_sext = 1'b0; t_addr = 11'h008; t_wdata = 64'hAA;
      t_valid = 1'b1;
      waited = 0;
      while (!o_req_ready && waited < 50) begin @(negedge clk); waited++; end
      @(posedge clk);
      #1 t_valid = 1'b0;
      @(negedge clk);
      n_tests++; if (o_req_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_in_wait got=%b exp=0", o_req_ready); end
      rst_n = 1'b0;
      #2;
      n_tests++; if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_async got=%b/%b exp=0/1", o_rsp_valid, o_req_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      dropped_ok = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) dropped_ok = 1'b0;
      end
      n_tests++; if (dropped_ok !== 1'b1) begin n_fail++; $display("FAIL midreset_dropped got=%b exp=1", dropped_ok); end
      ref_access(1, 1'b0, 2'd3, 1'b0, 11'h008, 64'd0, erd, eer);
      xact(1, 1'b0, 2'd3, 1'b0, 11'h008, 64'd0, 0, rd, er, lat, st, idl, ac);
      n_tests++; if (rd !== 64'hAA || rd !== erd) begin n_fail++; $display("FAIL midreset_committed got=%h exp=aa", rd); end
   endtask

`ifdef DMEM_WATCH_EN
   task automatic test_watch();
      logic [63:0] rd, erd; logic er; bit eer; int lat, ac; bit st, idl;
      n_tests++; if (watch1 !== mdl[0][6]) begin n_fail++; $display("FAIL watch_before got=%h exp=%h", watch1, mdl[0][6]); end
      ref_access(0, 1'b1, 2'd3, 1'b0, 11'h030, 64'h00000000DEADBEEF, erd, eer);
      xact(0, 1'b1, 2'd3, 1'b0, 11'h030, 64'h00000000DEADBEEF, 0, rd, er, lat, st, idl, ac);
      n_tests++; if (watch1 !== 64'h00000000DEADBEEF) begin n_fail++; $display("FAIL watch_after got=%h exp=deadbeef", watch1); end
   endtask
`endif

   task automatic test_back_to_back();
      logic [63:0] rd, erd; logic er; bit eer; int lat, ac, prev; bit st, idl;
      for (int s = 0; s < 2; s++) begin
         prev = -1;
         for (int i = 0; i < 4; i++) begin
            ref_access(s, 1'b0, 2'd3, 1'b0, 11'h030, 64'd0, erd, eer);
            xact(s, 1'b0, 2'd3, 1'b0, 11'h030, 64'd0, 0, rd, er, lat, st, idl, ac);
            n_tests++; if (rd !== erd) begin n_fail++; $display("FAIL b2b_rdata sel=%0d got=%h exp=%h", s, rd, erd); end
            if (prev >= 0) begin
               n_tests++; if (ac - prev !== lat_of(s) + 1) begin n_fail++; $display("FAIL b2b_spacing sel=%0d got=%0d exp=%0d", s, ac - prev, lat_of(s) + 1); end
            end
            prev = ac;
         end
      end
   endtask

   task automatic test_random();
      logic [63:0] rd, erd, wd; logic er; bit eer; int lat, ac; bit st, idl;
      bit we, sx; logic [1:0] sz; int idx, off, hold;
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 80; i++) begin
            we = 1'($urandom_range(0, 1));
            sx = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            idx = ($urandom_range(0, 9) == 0) ? $urandom_range(195, 255) : $urandom_range(0, 15);
            off = $urandom_range(0, 7);
            if ($urandom_range(0, 9) < 7) off = off - (off % (1 << sz));
            wd = {$urandom, $urandom};
            hold = $urandom_range(0, 2);
            ref_access(s, we, sz, sx, 11'(idx * 8 + off), wd, erd, eer);
            xact(s, we, sz, sx, 11'(idx * 8 + off), wd, hold, rd, er, lat, st, idl, ac);
            n_tests++;
            if (rd !== erd || er !== eer || lat !== lat_of(s) || st !== 1'b1 || idl !== 1'b1) begin
               n_fail++;
               $display("FAIL random sel=%0d we=%0d sz=%0d sx=%0d addr=%h got rd=%h err=%b lat=%0d st=%b idle=%b exp rd=%h err=%b lat=%0d",
                        s, we, sz, sx, 11'(idx * 8 + off), rd, er, lat, st, idl, erd, eer, lat_of(s));
            end
         end
      end
   endtask

   initial begin
      for (int s = 0; s < 2; s++) for (int i = 0; i < 256; i++) mdl[s][i] = 64'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      prefill();
      test_dword_store_load();
      test_byte_sext();
      test_errors();
      test_latency_hold();
      test_reset_mid();
`ifdef DMEM_WATCH_EN
      test_watch();
`endif
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
